id_ctrl: RTL and testbench
==========================

Name: id_ctrl

Overview:
- Decode-stage controller for the pipelined RV32I core.
- Decodes the IF/ID instruction opcode, drives the immediate-type select into the ID-stage immediate generator (combinational), and registers control fields into the ID/EX pipeline register.
- Sequences load-use bubbles, EX back-pressure and branch flushes, and counts bubble cycles.

Parameters:
CNT_W, 16, width of the saturating bubble-cycle counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_instr  in  32  instruction from IF/ID register
i_instr_vld  in  1  IF/ID holds a valid instruction
i_flush  in  1  EX resolved taken branch/jump; kill ID content
i_ex_ready  in  1  EX can accept a new ID/EX entry this cycle
o_stall_if  out  1  hold PC and IF/ID register
o_imm_sel  out  3  immediate type to the immediate generator (combinational)
o_ex_vld  out  1  ID/EX entry valid
o_ex_rd  out  5  destination register
o_ex_rs1  out  5  source 1 index
o_ex_rs2  out  5  source 2 index
o_ex_funct3  out  3  funct3 field
o_ex_wb_en  out  1  writes rd (forced 0 when rd==0)
o_ex_is_load / o_ex_is_store / o_ex_is_branch / o_ex_is_jal / o_ex_is_jalr  out  1 each  class flags
o_ex_opa_pc  out  1  operand A = PC (AUIPC, JAL)
o_ex_opb_imm  out  1  operand B = immediate (all except OP, BRANCH)
o_ex_illegal  out  1  unrecognised opcode
o_bubble_cnt  out  CNT_W  saturating count of bubble cycles inserted

Behaviour:
- o_imm_sel is combinational on i_instr[6:0]:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, OP 0110011 -> 3'b011 (I).
  - STORE 0100011 -> 3'b000 (S).
  - BRANCH 1100011 -> 3'b001 (B).
  - JAL 1101111 -> 3'b010 (J).
  - LUI 0110111, AUIPC 0010111 -> 3'b110 (U).
  - Any other opcode -> 3'b011 with illegal=1.
- Source usage:
  - rs1 is used by all recognised opcodes except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH.
- Load-use hazard: hz = o_ex_vld & o_ex_is_load & o_ex_rd!=0 & i_instr_vld & ((rs1 used & rs1==o_ex_rd) | (rs2 used & rs2==o_ex_rd)).
- FSM states RUN and BUBBLE, reset state RUN.
  - RUN, hz & i_ex_ready & !i_flush -> BUBBLE. That edge loads a bubble (o_ex_vld=0), and o_stall_if=1 in that cycle.
  - BUBBLE -> RUN unconditionally next cycle. The instruction in ID is now hazard-free, and o_stall_if follows the normal rules.
- Stall and load priority, highest first:
  1. i_flush: ID/EX <= bubble, o_stall_if=0, FSM -> RUN. Flush overrides back-pressure.
  2. !i_ex_ready: ID/EX holds its contents, o_stall_if=1, FSM state unchanged.
  3. hz: bubble as above.
  4. Otherwise: ID/EX <= decode of i_instr, with o_ex_vld = i_instr_vld; o_stall_if=0.
- Latency: one cycle from an i_instr presentation to the ID/EX outputs.
- A bubble or invalid entry has o_ex_vld=0 and all class flags, wb_en and illegal at 0. Index fields are don't-care but are cleared to 0.
- o_ex_illegal is set only when i_instr_vld=1. An illegal instruction is passed with o_ex_vld=1 and wb_en=0.
- o_bubble_cnt increments by 1 on every rising edge that loads a bubble because of hz or i_flush. It saturates at all-ones and never wraps. Holds under back-pressure do not count.
- Reset (async, takes effect immediately and also mid-stall):
  - All o_ex_* outputs = 0, o_bubble_cnt = 0, FSM = RUN.
  - o_stall_if = 0.
  - o_imm_sel still tracks i_instr combinationally.
- o_stall_if is combinational: (!i_flush & !i_ex_ready) | (!i_flush & hz & state==RUN).

Test Plan:
- Opcode sweep, one instruction per cycle, i_ex_ready=1: LW/ADDI/JALR/ADD -> imm_sel 011; SW -> 000; BEQ -> 001; JAL -> 010; LUI/AUIPC -> 110; opcode 1111111 -> illegal=1, wb_en=0. Each result appears on o_ex_* exactly one cycle later.
- LW x5,0(x1) followed by ADD x6,x5,x2 -> o_stall_if=1 for one cycle, one o_ex_vld=0 cycle, ADD issued the next cycle, o_bubble_cnt=1. Repeat with rd=x0 and with LUI x6 (rs1 unused) -> no stall.
- i_ex_ready=0 for 3 cycles while holding ADDI -> o_ex_* frozen, o_stall_if=1 for 3 cycles, o_bubble_cnt unchanged.
- i_flush=1 together with a load-use hazard and i_ex_ready=0 -> next cycle o_ex_vld=0, o_stall_if=0 in the flush cycle, FSM=RUN, counter +1.
- CNT_W=4: force 20 hazard bubbles -> o_bubble_cnt sticks at 15.
- Assert i_rst for half a cycle while in BUBBLE state -> outputs clear immediately, without waiting for a clock edge; after release, the first valid instruction decodes normally.

Source files
------------

// File: rtl/id_ctrl.sv
// Decode-stage controller: decodes IF/ID, feeds imm type to immgen, registers ID/EX control fields.
// Latency: o_imm_sel and o_stall_if combinational; ID/EX entry one cycle after presentation.
// Backpressure: !i_ex_ready holds ID/EX and stalls IF; flush overrides; load-use inserts one bubble.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_instr, i_instr_vld    IF/ID instruction and its valid
//   i_flush, i_ex_ready     taken-branch kill from EX, EX accept
//   o_stall_if, o_imm_sel   IF hold request, immediate type (both combinational)
//   o_ex_*                  registered ID/EX control entry
//   o_bubble_cnt            saturating count of inserted bubbles (hazard or flush)
module id_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_instr,
    input  logic             i_instr_vld,
    input  logic             i_flush,
    input  logic             i_ex_ready,
    output logic             o_stall_if,
    output logic [2:0]       o_imm_sel,
    output logic             o_ex_vld,
    output logic [4:0]       o_ex_rd,
    output logic [4:0]       o_ex_rs1,
    output logic [4:0]       o_ex_rs2,
    output logic [2:0]       o_ex_funct3,
    output logic             o_ex_wb_en,
    output logic             o_ex_is_load,
    output logic             o_ex_is_store,
    output logic             o_ex_is_branch,
    output logic             o_ex_is_jal,
    output logic             o_ex_is_jalr,
    output logic             o_ex_opa_pc,
    output logic             o_ex_opb_imm,
    output logic             o_ex_illegal,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_S = 3'b000;
    localparam logic [2:0] IMM_B = 3'b001;
    localparam logic [2:0] IMM_J = 3'b010;
    localparam logic [2:0] IMM_I = 3'b011;
    localparam logic [2:0] IMM_U = 3'b110;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       wb_en;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       opa_pc;
        logic       opb_imm;
        logic       illegal;
    } ex_ent_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    ex_ent_t          ex_q, ex_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] f_rd, f_rs1, f_rs2;
    logic [2:0] f_funct3;
    logic       unused_imm_hi;

    assign opcode        = i_instr[6:0];
    assign f_rd          = i_instr[11:7];
    assign f_funct3      = i_instr[14:12];
    assign f_rs1         = i_instr[19:15];
    assign f_rs2         = i_instr[24:20];
    assign unused_imm_hi = ^i_instr[31:25];

    // Opcode decode
    logic [2:0] imm_sel;
    logic       d_load, d_store, d_branch, d_jal, d_jalr;
    logic       d_op, d_opimm, d_lui, d_auipc, d_known;
    logic       rs1_used, rs2_used, writes_rd;

    always_comb begin
        imm_sel  = IMM_I;
        d_load   = 1'b0;
        d_store  = 1'b0;
        d_branch = 1'b0;
        d_jal    = 1'b0;
        d_jalr   = 1'b0;
        d_op     = 1'b0;
        d_opimm  = 1'b0;
        d_lui    = 1'b0;
        d_auipc  = 1'b0;
        case (opcode)
            OPC_LOAD:   d_load   = 1'b1;
            OPC_OPIMM:  d_opimm  = 1'b1;
            OPC_JALR:   d_jalr   = 1'b1;
            OPC_OP:     d_op     = 1'b1;
            OPC_STORE:  begin d_store  = 1'b1; imm_sel = IMM_S; end
            OPC_BRANCH: begin d_branch = 1'b1; imm_sel = IMM_B; end
            OPC_JAL:    begin d_jal    = 1'b1; imm_sel = IMM_J; end
            OPC_LUI:    begin d_lui    = 1'b1; imm_sel = IMM_U; end
            OPC_AUIPC:  begin d_auipc  = 1'b1; imm_sel = IMM_U; end
            default:    imm_sel = IMM_I;
        endcase
    end

    assign d_known   = d_load | d_store | d_branch | d_jal | d_jalr |
                       d_op | d_opimm | d_lui | d_auipc;
    assign rs1_used  = d_known & ~(d_lui | d_auipc | d_jal);
    assign rs2_used  = d_op | d_store | d_branch;
    assign writes_rd = d_load | d_opimm | d_jalr | d_op | d_jal | d_lui | d_auipc;

    assign o_imm_sel = imm_sel;

    // Load-use hazard against the load currently sitting in ID/EX
    logic hz, hz_run;

    assign hz = ex_q.vld & ex_q.is_load & (ex_q.rd != 5'd0) & i_instr_vld &
                ((rs1_used & (f_rs1 == ex_q.rd)) | (rs2_used & (f_rs2 == ex_q.rd)));
    // In BUBBLE the load has already been separated from its consumer
    assign hz_run = hz & (state_q == ST_RUN);

    // Entry built from the current instruction; invalid slots are all-zero
    ex_ent_t dec_ent;

    always_comb begin
        dec_ent = '0;
        if (i_instr_vld) begin
            dec_ent.vld       = 1'b1;
            dec_ent.rd        = f_rd;
            dec_ent.rs1       = f_rs1;
            dec_ent.rs2       = f_rs2;
            dec_ent.funct3    = f_funct3;
            dec_ent.wb_en     = writes_rd & (f_rd != 5'd0);
            dec_ent.is_load   = d_load;
            dec_ent.is_store  = d_store;
            dec_ent.is_branch = d_branch;
            dec_ent.is_jal    = d_jal;
            dec_ent.is_jalr   = d_jalr;
            dec_ent.opa_pc    = d_auipc | d_jal;
            dec_ent.opb_imm   = d_known & ~(d_op | d_branch);
            dec_ent.illegal   = ~d_known;
        end
    end

    // Next-state: flush > back-pressure > hazard bubble > normal issue
    logic cnt_inc;

    always_comb begin
        ex_d    = ex_q;
        state_d = state_q;
        cnt_inc = 1'b0;
        if (i_flush) begin
            ex_d    = '0;
            state_d = ST_RUN;
            cnt_inc = 1'b1;
        end else if (!i_ex_ready) begin
            ex_d    = ex_q;
            state_d = state_q;
        end else if (hz_run) begin
            ex_d    = '0;
            state_d = ST_BUBBLE;
            cnt_inc = 1'b1;
        end else begin
            ex_d    = dec_ent;
            state_d = ST_RUN;
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_inc && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_q         <= '0;
            state_q      <= ST_RUN;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            state_q      <= state_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Reset gating keeps IF free-running while the controller is held in reset
    assign o_stall_if = ~i_rst & ~i_flush & (~i_ex_ready | hz_run);

    assign o_ex_vld       = ex_q.vld;
    assign o_ex_rd        = ex_q.rd;
    assign o_ex_rs1       = ex_q.rs1;
    assign o_ex_rs2       = ex_q.rs2;
    assign o_ex_funct3    = ex_q.funct3;
    assign o_ex_wb_en     = ex_q.wb_en;
    assign o_ex_is_load   = ex_q.is_load;
    assign o_ex_is_store  = ex_q.is_store;
    assign o_ex_is_branch = ex_q.is_branch;
    assign o_ex_is_jal    = ex_q.is_jal;
    assign o_ex_is_jalr   = ex_q.is_jalr;
    assign o_ex_opa_pc    = ex_q.opa_pc;
    assign o_ex_opb_imm   = ex_q.opb_imm;
    assign o_ex_illegal   = ex_q.illegal;
    assign o_bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ctrl.sv
// Directed testbench for id_ctrl with a 4-bit bubble counter.
// Latency: checks combinational outputs before the edge, registered outputs 1ns after it.
// Backpressure: exercises EX hold, load-use bubble, flush and counter saturation.
module tb_id_ctrl;

    localparam int CNT_W = 4;

    logic             i_clk;
    logic             i_rst;
    logic [31:0]      i_instr;
    logic             i_instr_vld;
    logic             i_flush;
    logic             i_ex_ready;
    logic             o_stall_if;
    logic [2:0]       o_imm_sel;
    logic             o_ex_vld;
    logic [4:0]       o_ex_rd;
    logic [4:0]       o_ex_rs1;
    logic [4:0]       o_ex_rs2;
    logic [2:0]       o_ex_funct3;
    logic             o_ex_wb_en;
    logic             o_ex_is_load;
    logic             o_ex_is_store;
    logic             o_ex_is_branch;
    logic             o_ex_is_jal;
    logic             o_ex_is_jalr;
    logic             o_ex_opa_pc;
    logic             o_ex_opb_imm;
    logic             o_ex_illegal;
    logic [CNT_W-1:0] o_bubble_cnt;

    id_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_instr        (i_instr),
        .i_instr_vld    (i_instr_vld),
        .i_flush        (i_flush),
        .i_ex_ready     (i_ex_ready),
        .o_stall_if     (o_stall_if),
        .o_imm_sel      (o_imm_sel),
        .o_ex_vld       (o_ex_vld),
        .o_ex_rd        (o_ex_rd),
        .o_ex_rs1       (o_ex_rs1),
        .o_ex_rs2       (o_ex_rs2),
        .o_ex_funct3    (o_ex_funct3),
        .o_ex_wb_en     (o_ex_wb_en),
        .o_ex_is_load   (o_ex_is_load),
        .o_ex_is_store  (o_ex_is_store),
        .o_ex_is_branch (o_ex_is_branch),
        .o_ex_is_jal    (o_ex_is_jal),
        .o_ex_is_jalr   (o_ex_is_jalr),
        .o_ex_opa_pc    (o_ex_opa_pc),
        .o_ex_opb_imm   (o_ex_opb_imm),
        .o_ex_illegal   (o_ex_illegal),
        .o_bubble_cnt   (o_bubble_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction word from fields (imm[11:5]/funct7 left zero)
    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        mk = {7'b0, rs2, rs1, f3, rd, op};
    endfunction

    // Expected ID/EX vector; flags = {load, store, branch, jal, jalr}
    function automatic logic [27:0] ev(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [2:0] f3, input logic wb,
                                       input logic [4:0] flags, input logic opa, input logic opb,
                                       input logic ill);
        ev = {v, rd, rs1, rs2, f3, wb, flags, opa, opb, ill};
    endfunction

    function automatic logic [27:0] exv();
        exv = {o_ex_vld, o_ex_rd, o_ex_rs1, o_ex_rs2, o_ex_funct3, o_ex_wb_en,
               o_ex_is_load, o_ex_is_store, o_ex_is_branch, o_ex_is_jal, o_ex_is_jalr,
               o_ex_opa_pc, o_ex_opb_imm, o_ex_illegal};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, input logic fl, input logic rdy);
        i_instr     = ins;
        i_instr_vld = v;
        i_flush     = fl;
        i_ex_ready  = rdy;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bump_cnt();
        if (exp_cnt < 15) exp_cnt++;
    endtask

    // One instruction per cycle: imm_sel and no stall now, entry one edge later
    task automatic sweep_one(input string tag, input logic [31:0] ins, input logic [2:0] imm,
                             input logic [27:0] expv);
        drive(ins, 1'b1, 1'b0, 1'b1);
        #1;
        chk({tag, "_imm"}, 32'(o_imm_sel), 32'(imm));
        chk({tag, "_stall"}, 32'(o_stall_if), 32'd0);
        step();
        chk({tag, "_ex"}, 32'(exv()), 32'(expv));
    endtask

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] BAD   = 7'b1111111;

    logic [31:0] lw_x5, add_dep, addi_i;

    initial begin
        lw_x5   = mk(LOAD, 5'd5, 3'd2, 5'd1, 5'd0);
        add_dep = mk(OP, 5'd6, 3'd0, 5'd5, 5'd2);
        addi_i  = mk(OPIMM, 5'd7, 3'd0, 5'd3, 5'd4);

        // Reset state, with back-pressure asserted to show stall is gated
        i_rst = 1'b1;
        drive(mk(JAL, 5'd1, 3'd0, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        #3;
        chk("rst_stall", 32'(o_stall_if), 32'd0);
        chk("rst_ex", 32'(exv()), 32'd0);
        chk("rst_cnt", 32'(o_bubble_cnt), 32'd0);
        chk("rst_imm", 32'(o_imm_sel), 32'd2);
        step();
        i_rst = 1'b0;

        // Opcode sweep
        sweep_one("lw",    lw_x5, 3'b011, ev(1, 5, 1, 0, 2, 1, 5'b10000, 0, 1, 0));
        sweep_one("addi",  addi_i, 3'b011, ev(1, 7, 3, 4, 0, 1, 5'b00000, 0, 1, 0));
        sweep_one("jalr",  mk(JALR, 5'd1, 3'd0, 5'd8, 5'd0), 3'b011,
                  ev(1, 1, 8, 0, 0, 1, 5'b00001, 0, 1, 0));
        sweep_one("add",   mk(OP, 5'd9, 3'd0, 5'd10, 5'd11), 3'b011,
                  ev(1, 9, 10, 11, 0, 1, 5'b00000, 0, 0, 0));
        sweep_one("sw",    mk(STORE, 5'd4, 3'd2, 5'd13, 5'd12), 3'b000,
                  ev(1, 4, 13, 12, 2, 0, 5'b01000, 0, 1, 0));
        sweep_one("beq",   mk(BR, 5'd8, 3'd0, 5'd14, 5'd15), 3'b001,
                  ev(1, 8, 14, 15, 0, 0, 5'b00100, 0, 0, 0));
        sweep_one("jal",   mk(JAL, 5'd1, 3'd0, 5'd0, 5'd0), 3'b010,
                  ev(1, 1, 0, 0, 0, 1, 5'b00010, 1, 1, 0));
        sweep_one("lui",   mk(LUI, 5'd16, 3'd3, 5'd17, 5'd18), 3'b110,
                  ev(1, 16, 17, 18, 3, 1, 5'b00000, 0, 1, 0));
        sweep_one("auipc", mk(AUIPC, 5'd17, 3'd1, 5'd2, 5'd3), 3'b110,
                  ev(1, 17, 2, 3, 1, 1, 5'b00000, 1, 1, 0));
        sweep_one("addi_x0", mk(OPIMM, 5'd0, 3'd0, 5'd0, 5'd0), 3'b011,
                  ev(1, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 0));

        // Invalid slot clears everything, indices included
        drive(mk(OP, 5'd9, 3'd0, 5'd10, 5'd11), 1'b0, 1'b0, 1'b1);
        step();
        chk("invalid_ex", 32'(exv()), 32'd0);

        // Illegal opcode passes as valid, no writeback
        drive(mk(BAD, 5'd5, 3'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1);
        #1;
        chk("ill_imm", 32'(o_imm_sel), 32'd3);
        step();
        chk("ill_flags", 32'({o_ex_vld, o_ex_illegal, o_ex_wb_en, o_ex_is_load, o_ex_is_store,
                              o_ex_is_branch, o_ex_is_jal, o_ex_is_jalr}), 32'b11000000);

        // Load-use via rs1: one stall, one bubble, then consumer issues
        sweep_one("lu_lw", lw_x5, 3'b011, ev(1, 5, 1, 0, 2, 1, 5'b10000, 0, 1, 0));
        drive(add_dep, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lu_stall", 32'(o_stall_if), 32'd1);
        step();
        bump_cnt();
        chk("lu_bubble", 32'(exv()), 32'd0);
        chk("lu_cnt", 32'(o_bubble_cnt), 32'(exp_cnt));
        chk("lu_stall2", 32'(o_stall_if), 32'd0);
        step();
        chk("lu_issue", 32'(exv()), 32'(ev(1, 6, 5, 2, 0, 1, 5'b00000, 0, 0, 0)));
        chk("lu_cnt2", 32'(o_bubble_cnt), 32'(exp_cnt));

        // Load-use via rs2 (store data)
        sweep_one("lu2_lw", lw_x5, 3'b011, ev(1, 5, 1, 0, 2, 1, 5'b10000, 0, 1, 0));
        drive(mk(STORE, 5'd0, 3'd2, 5'd3, 5'd5), 1'b1, 1'b0, 1'b1);
        #1;
        chk("lu2_stall", 32'(o_stall_if), 32'd1);
        step();
        bump_cnt();
        chk("lu2_vld", 32'(o_ex_vld), 32'd0);
        step();

        // No hazard for a load to x0
        sweep_one("x0_lw", mk(LOAD, 5'd0, 3'd2, 5'd1, 5'd0), 3'b011,
                  ev(1, 0, 1, 0, 2, 0, 5'b10000, 0, 1, 0));
        sweep_one("x0_add", mk(OP, 5'd6, 3'd0, 5'd0, 5'd2), 3'b011,
                  ev(1, 6, 0, 2, 0, 1, 5'b00000, 0, 0, 0));

        // No hazard when the consumer's rs fields are not real sources
        sweep_one("lui_lw", lw_x5, 3'b011, ev(1, 5, 1, 0, 2, 1, 5'b10000, 0, 1, 0));
        sweep_one("lui_dep", mk(LUI, 5'd6, 3'd0, 5'd5, 5'd5), 3'b110,
                  ev(1, 6, 5, 5, 0, 1, 5'b00000, 0, 1, 0));
        chk("lui_cnt", 32'(o_bubble_cnt), 32'(exp_cnt));

        // EX back-pressure for 3 cycles freezes ID/EX
        sweep_one("bp_addi", addi_i, 3'b011, ev(1, 7, 3, 4, 0, 1, 5'b00000, 0, 1, 0));
        for (int i = 0; i < 3; i++) begin
            drive(mk(OP, 5'd9, 3'd0, 5'd10, 5'd11), 1'b1, 1'b0, 1'b0);
            #1;
            chk($sformatf("bp_stall%0d", i), 32'(o_stall_if), 32'd1);
            step();
            chk($sformatf("bp_hold%0d", i), 32'(exv()),
                32'(ev(1, 7, 3, 4, 0, 1, 5'b00000, 0, 1, 0)));
        end
        chk("bp_cnt", 32'(o_bubble_cnt), 32'(exp_cnt));
        drive(mk(OP, 5'd9, 3'd0, 5'd10, 5'd11), 1'b1, 1'b0, 1'b1);
        step();
        chk("bp_release", 32'(exv()), 32'(ev(1, 9, 10, 11, 0, 1, 5'b00000, 0, 0, 0)));

        // Flush beats hazard and back-pressure
        sweep_one("fl_lw", lw_x5, 3'b011, ev(1, 5, 1, 0, 2, 1, 5'b10000, 0, 1, 0));
        drive(add_dep, 1'b1, 1'b1, 1'b0);
        #1;
        chk("fl_stall", 32'(o_stall_if), 32'd0);
        step();
        bump_cnt();
        chk("fl_ex", 32'(exv()), 32'd0);
        chk("fl_cnt", 32'(o_bubble_cnt), 32'(exp_cnt));
        sweep_one("fl_after", add_dep, 3'b011, ev(1, 6, 5, 2, 0, 1, 5'b00000, 0, 0, 0));

        // Saturation: 20 more hazard bubbles on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(lw_x5, 1'b1, 1'b0, 1'b1);
            step();
            drive(add_dep, 1'b1, 1'b0, 1'b1);
            step();
            bump_cnt();
            step();
        end
        chk("sat_cnt", 32'(o_bubble_cnt), 32'(exp_cnt));
        chk("sat_max", 32'(o_bubble_cnt), 32'd15);

        // Async reset while in BUBBLE
        drive(lw_x5, 1'b1, 1'b0, 1'b1);
        step();
        drive(add_dep, 1'b1, 1'b0, 1'b1);
        step();
        drive(mk(JAL, 5'd1, 3'd0, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        #1;
        i_rst = 1'b1;
        #1;
        chk("arst_cnt", 32'(o_bubble_cnt), 32'd0);
        chk("arst_ex", 32'(exv()), 32'd0);
        chk("arst_stall", 32'(o_stall_if), 32'd0);
        chk("arst_imm", 32'(o_imm_sel), 32'd2);
        #3;
        i_rst = 1'b0;
        exp_cnt = 0;
        sweep_one("post_rst", addi_i, 3'b011, ev(1, 7, 3, 4, 0, 1, 5'b00000, 0, 1, 0));
        sweep_one("post_lw", lw_x5, 3'b011, ev(1, 5, 1, 0, 2, 1, 5'b10000, 0, 1, 0));
        drive(add_dep, 1'b1, 1'b0, 1'b1);
        #1;
        chk("post_stall", 32'(o_stall_if), 32'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
